// File: rtl/mmss_countdown_ctrl.sv
// Minutes:seconds BCD countdown controller for the kitchen timer.
// Holds an editable preset, counts down on a 1 Hz tick and flags expiry.
module mmss_countdown_ctrl #(
   parameter logic [7:0]  INIT_MIN   = 8'h01,
   parameter logic [7:0]  INIT_SEC   = 8'h00,
   parameter int unsigned DONE_TICKS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_tick,
   input  logic        i_start,
   input  logic        i_clear,
   input  logic        i_min_inc,
   input  logic        i_sec_inc,
   output logic [15:0] o_data,
   output logic [3:0]  o_dots,
   output logic        o_blank,
   output logic        o_running,
   output logic        o_done
);

   localparam int unsigned EV_START = 0;
   localparam int unsigned EV_CLEAR = 1;
   localparam int unsigned EV_MIN   = 2;
   localparam int unsigned EV_SEC   = 3;
   localparam logic [7:0]  DONE_LIMIT = 8'(DONE_TICKS);
   localparam logic [15:0] INIT_VAL   = {INIT_MIN, INIT_SEC};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   // Two-digit BCD increment wrapping from max to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // MM:SS BCD decrement with a borrow chain through all four digits.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [3:0] m1, m0, s1, s0;
      logic       b;
      {m1, m0, s1, s0} = v;
      b  = (s0 == 4'd0);
      s0 = b ? 4'd9 : s0 - 4'd1;
      if (b) begin
         b  = (s1 == 4'd0);
         s1 = b ? 4'd5 : s1 - 4'd1;
      end
      if (b) begin
         b  = (m0 == 4'd0);
         m0 = b ? 4'd9 : m0 - 4'd1;
      end
      if (b)
         m1 = m1 - 4'd1;
      return {m1, m0, s1, s0};
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  hist_q, hist_d;
   logic [15:0] preset_q, preset_d;
   logic [15:0] count_q, count_d;
   logic        colon_q, colon_d;
   logic        blank_q, blank_d;
   logic [7:0]  dtick_q, dtick_d;
   logic        running_q, running_d;
   logic        done_q, done_d;
   logic [3:0]  ev;
   logic [15:0] dec_cnt;

   assign dec_cnt = bcd_dec(count_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         hist_q    <= 4'b1111;
         preset_q  <= INIT_VAL;
         count_q   <= INIT_VAL;
         colon_q   <= 1'b1;
         blank_q   <= 1'b0;
         dtick_q   <= 8'd0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         colon_q   <= colon_d;
         blank_q   <= blank_d;
         dtick_q   <= dtick_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      count_d  = count_q;
      colon_d  = colon_q;
      blank_d  = blank_q;
      dtick_d  = dtick_q;
      hist_d   = {i_sec_inc, i_min_inc, i_clear, i_start};
      ev       = hist_d & ~hist_q;

      case (state_q)
         S_IDLE: begin
            if (ev[EV_MIN])
               preset_d[15:8] = bcd_inc(preset_q[15:8], 8'h99);
            if (ev[EV_SEC])
               preset_d[7:0] = bcd_inc(preset_q[7:0], 8'h59);
            count_d = preset_d;
            colon_d = 1'b1;
            if (ev[EV_START] && (preset_q != 16'h0000))
               state_d = S_RUN;
         end
         S_RUN: begin
            if (ev[EV_CLEAR]) begin
               state_d = S_IDLE;
               count_d = preset_q;
               colon_d = 1'b1;
            end else begin
               if (i_tick) begin
                  if (dec_cnt == 16'h0000) begin
                     state_d = S_DONE;
                     count_d = 16'h0000;
                     colon_d = 1'b1;
                     dtick_d = 8'd0;
                     blank_d = 1'b0;
                  end else begin
                     count_d = dec_cnt;
                     colon_d = ~colon_q;
                  end
               end
               // A tick that expires the count wins over a pause request.
               if (ev[EV_START] && (state_d != S_DONE)) begin
                  state_d = S_PAUSE;
                  colon_d = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (ev[EV_CLEAR]) begin
               state_d = S_IDLE;
               count_d = preset_q;
            end else if (ev[EV_START]) begin
               state_d = S_RUN;
               colon_d = 1'b1;
            end
         end
         S_DONE: begin
            if (ev[EV_CLEAR] || ev[EV_START]) begin
               state_d = S_IDLE;
               count_d = preset_q;
               blank_d = 1'b0;
            end else if (i_tick) begin
               dtick_d = dtick_q + 8'd1;
               if (dtick_d == DONE_LIMIT) begin
                  state_d = S_IDLE;
                  count_d = preset_q;
                  blank_d = 1'b0;
               end else begin
                  blank_d = ~blank_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_DONE);
   end

   assign o_data    = count_q;
   assign o_dots    = {1'b0, colon_q, 2'b00};
   assign o_blank   = blank_q;
   assign o_running = running_q;
   assign o_done    = done_q;

endmodule

// File: tb/tb_mmss_countdown_ctrl.sv
// Scoreboard bench for mmss_countdown_ctrl: a seconds-based reference model
// predicts every cycle's outputs; a separate monitor compares them.
module tb_mmss_countdown_ctrl;

   logic        clk;
   logic        rst;
   logic        i_tick, i_start, i_clear, i_min_inc, i_sec_inc;
   logic [15:0] o_data;
   logic [3:0]  o_dots;
   logic        o_blank, o_running, o_done;

   mmss_countdown_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (i_tick),
      .i_start   (i_start),
      .i_clear   (i_clear),
      .i_min_inc (i_min_inc),
      .i_sec_inc (i_sec_inc),
      .o_data    (o_data),
      .o_dots    (o_dots),
      .o_blank   (o_blank),
      .o_running (o_running),
      .o_done    (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   // Reference model: time kept as plain seconds, preset as integer fields.
   int  m_state, pre_m, pre_s, cnt, dticks;
   bit  colon, blank;
   bit  h[4];
   logic [22:0] expq[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   function automatic logic [22:0] exp_vec();
      int mm, ss;
      mm = cnt / 60;
      ss = cnt % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              1'b0, colon, 2'b00, blank, (m_state == M_RUN), (m_state == M_DONE)};
   endfunction

   function automatic void model_reset();
      m_state = M_IDLE; pre_m = 1; pre_s = 0; cnt = 60;
      dticks = 0; colon = 1; blank = 0;
      h = '{1, 1, 1, 1};
   endfunction

   function automatic void go_idle();
      m_state = M_IDLE;
      cnt     = pre_m * 60 + pre_s;
      blank   = 0;
      colon   = 1;
   endfunction

   function automatic void model_step(bit st, bit cl, bit mi, bit si, bit tk);
      bit es, ec, emi, esi, was_zero, expired;
      es = st && !h[0]; ec = cl && !h[1]; emi = mi && !h[2]; esi = si && !h[3];
      h[0] = st; h[1] = cl; h[2] = mi; h[3] = si;
      case (m_state)
         M_IDLE: begin
            was_zero = (pre_m == 0) && (pre_s == 0);
            if (emi) pre_m = (pre_m + 1) % 100;
            if (esi) pre_s = (pre_s + 1) % 60;
            cnt = pre_m * 60 + pre_s;
            if (es && !was_zero) begin
               m_state = M_RUN;
               colon   = 1;
            end
         end
         M_RUN: begin
            if (ec) go_idle();
            else begin
               expired = 0;
               if (tk) begin
                  cnt = cnt - 1;
                  if (cnt == 0) begin
                     m_state = M_DONE; dticks = 0; blank = 0; colon = 1; expired = 1;
                  end else colon = !colon;
               end
               if (es && !expired) begin
                  m_state = M_PAUSE;
                  colon   = 1;
               end
            end
         end
         M_PAUSE: begin
            if (ec) go_idle();
            else if (es) begin
               m_state = M_RUN;
               colon   = 1;
            end
         end
         default: begin
            if (ec || es) go_idle();
            else if (tk) begin
               dticks++;
               if (dticks == 10) go_idle();
               else blank = !blank;
            end
         end
      endcase
   endfunction

   task automatic apply(bit st, bit cl, bit mi, bit si, bit tk);
      i_start = st; i_clear = cl; i_min_inc = mi; i_sec_inc = si; i_tick = tk;
      model_step(st, cl, mi, si, tk);
      expq.push_back(exp_vec());
   endtask

   task automatic cyc(bit st, bit cl, bit mi, bit si, bit tk);
      @(negedge clk);
      apply(st, cl, mi, si, tk);
   endtask

   // b: 0 start, 1 clear, 2 min_inc, 3 sec_inc
   task automatic press(int b);
      cyc(b == 0, b == 1, b == 2, b == 3, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic ticks(int n);
      repeat (n) cyc(0, 0, 0, 0, 1);
   endtask

   task automatic check_now(string name);
      logic [22:0] act, e;
      act = {o_data, o_dots, o_blank, o_running, o_done};
      e   = exp_vec();
      n_checks++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s t=%0t got %h required %h", name, $time, act, e);
      end
   endtask

   task automatic expect16(string name, logic [15:0] act, logic [15:0] e);
      n_checks++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s t=%0t got %h required %h", name, $time, act, e);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Async reset asserted between edges; outputs must change with no clock edge.
   task automatic do_reset(bit hold_start, string name);
      @(negedge clk);
      #2;
      rst = 1'b1;
      i_start = hold_start; i_clear = 0; i_min_inc = 0; i_sec_inc = 0; i_tick = 0;
      #1;
      model_reset();
      check_now(name);
      @(negedge clk);
      rst = 1'b0;
      apply(hold_start, 0, 0, 0, 0);
   endtask

   // Monitor: one expected snapshot per active edge.
   initial begin
      logic [22:0] e, act;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e   = expq.pop_front();
            act = {o_data, o_dots, o_blank, o_running, o_done};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL cycle_check t=%0t data=%h dots=%b blank=%b run=%b done=%b required data=%h dots=%b blank=%b run=%b done=%b",
                        $time, act[22:7], act[6:3], act[2], act[1], act[0],
                        e[22:7], e[6:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      bit st, cl, mi, si;
      rst = 1'b1;
      i_tick = 0; i_start = 0; i_clear = 0; i_min_inc = 0; i_sec_inc = 0;
      model_reset();

      // Preset editing
      do_reset(0, "reset_initial");
      repeat (3) press(2);
      repeat (2) press(3);
      settle();
      expect16("preset_0402", o_data, 16'h0402);
      expect16("preset_not_running", {15'd0, o_running}, 16'd0);

      // 00:02 run to expiry, then automatic return
      do_reset(0, "reset_run2");
      repeat (99) press(2);
      repeat (2) press(3);
      press(0);
      ticks(2);
      settle();
      expect16("expired_done", {o_data[15:1], o_done}, 16'h0001);
      ticks(10);
      settle();
      expect16("auto_idle_data", o_data, 16'h0002);

      // Borrow chain 10:00 -> 09:59
      do_reset(0, "reset_borrow");
      repeat (9) press(2);
      press(0);
      ticks(1);
      settle();
      expect16("borrow_0959", o_data, 16'h0959);

      // Pause and clear at 00:59
      do_reset(0, "reset_pause");
      repeat (99) press(2);
      repeat (59) press(3);
      press(0);
      press(0);
      ticks(3);
      press(0);
      ticks(1);
      settle();
      expect16("resume_0058", o_data, 16'h0058);
      press(1);

      // Seconds wrap 59 -> 00 with minutes unchanged, minutes wrap 99 -> 00
      press(3);
      repeat (99) press(2);
      settle();
      expect16("min_99", o_data, 16'h9900);
      press(2);
      settle();
      expect16("min_wrap", o_data, 16'h0000);

      // Start with zero preset is ignored
      press(0);
      settle();
      expect16("zero_start_ignored", {15'd0, o_running}, 16'd0);

      // Start held through reset release
      do_reset(1, "reset_held");
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      settle();
      expect16("held_start_no_event", {15'd0, o_running}, 16'd0);

      // Tick + start at 00:05, then clear + start
      do_reset(0, "reset_simul");
      repeat (99) press(2);
      repeat (5) press(3);
      press(0);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      settle();
      expect16("tick_start_0004", o_data, 16'h0004);
      press(0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      ticks(2);
      do_reset(0, "reset_mid_run_prep");
      press(0);
      ticks(3);
      do_reset(0, "async_reset_in_run");

      // Randomized stimulus
      repeat (99) press(2);
      st = 0; cl = 0; mi = 0; si = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) st = !st;
         if ($urandom_range(0, 63) == 0) cl = !cl;
         if ($urandom_range(0, 7) == 0)  mi = !mi;
         if ($urandom_range(0, 5) == 0)  si = !si;
         cyc(st, cl, mi, si, 1'($urandom_range(0, 1)));
      end
      cyc(0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      n_checks++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain pending=%0d required 0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
